mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//   Memory stage of the 8-bit MIPS pipeline, directly downstream of the EX/MEM
//   register. It consumes the registered ALU result (ans_ex), the store data
//   (DM_data) and the MEM control bits. It owns the data memory and models a
//   configurable access latency. While a memory access is in progress it stalls
//   upstream. At completion it loads the MEM/WB register that feeds write-back.
// PARAMETERS
//   ADDR_W   5   data-memory address width; depth = 2**ADDR_W bytes, address = ans_ex[ADDR_W-1:0]
//   MEM_LAT  0   extra wait cycles per load/store (0..15); non-memory ops never wait
// PORTS
//   clk        in   1  rising-edge clock
//   reset      in   1  synchronous, active-low reset
//   ans_ex     in   8  ALU result from EX/MEM; memory address for loads and stores
//   DM_data    in   8  store data from EX/MEM
//   mem_rd     in   1  load in this slot
//   mem_wr     in   1  store in this slot
//   wb_en_in   in   1  instruction writes the register file
//   rd_in      in   3  destination register index
//   stall      out  1  combinational; upstream holds all inputs while 1
//   wb_data    out  8  MEM/WB: load data or pass-through ALU result
//   wb_rd      out  3  MEM/WB destination index
//   wb_en      out  1  MEM/WB write enable; 0 means bubble
// BEHAVIOUR
//   - Reset (reset==0 at posedge): state=IDLE, cnt=0, wb_data=0, wb_rd=0, wb_en=0.
//     Memory contents are NOT cleared. Reset overrides every other action.
//   - stall = (state==IDLE & (mem_rd|mem_wr) & MEM_LAT!=0) | (state==WAIT & cnt!=0).
//   - FSM IDLE: if a memory op is present and MEM_LAT>0, go to WAIT with cnt=MEM_LAT-1.
//     Otherwise the op commits at this edge.
//   - FSM WAIT: if cnt!=0, decrement cnt. If cnt==0, commit and go to IDLE.
//   - Timing: an op first presented in cycle t has stall=1 in cycles t..t+MEM_LAT-1
//     and commits at the edge ending cycle t+MEM_LAT. wb_* are valid in the
//     following cycle. Non-memory ops commit at the end of cycle t with no stall.
//   - Commit: if mem_wr, mem[addr] <= DM_data. MEM/WB loads wb_rd=rd_in and
//     wb_en=wb_en_in. wb_data = mem_rd ? mem[addr] (pre-write contents) : ans_ex.
//   - Each edge with stall=1 loads a bubble: wb_en=0. wb_data and wb_rd hold.
//   - mem_rd and mem_wr both 1: treated as a store. The read is ignored and
//     wb_data=ans_ex.
//   - Address uses ans_ex[ADDR_W-1:0]. Upper bits are ignored, so addresses wrap.
//   - A store is written to memory only at commit. Reset during WAIT aborts the
//     op: memory is unchanged and no MEM/WB entry is produced.
//   - A load immediately following a store to the same address (in the next
//     commit) returns the stored value.
// TESTING
//   1 Reset: drive reset=0 with mem_rd=1 -> wb_en=0, wb_data=0, wb_rd=0, stall=0.
//   2 MEM_LAT=0: store 8'hA5 at ans_ex=8'h03, then load from 8'h03 with rd_in=2,
//     wb_en_in=1 -> next cycle wb_data=8'hA5, wb_rd=2, wb_en=1, stall never 1.
//   3 MEM_LAT=2: a load at cycle t -> stall=1 in t and t+1, 0 in t+2; wb_en=0 in
//     t+1 and t+2; wb_en=1 with load data in t+3.
//   4 MEM_LAT=3: store 8'h5A to 8'h07, then reset=0 in the second stall cycle,
//     then load 8'h07 -> returns the old contents, not 8'h5A.
//   5 ALU pass-through: mem_rd=mem_wr=0, ans_ex=8'h3C, wb_en_in=1, rd_in=5 ->
//     next cycle wb_data=8'h3C, wb_rd=5, wb_en=1, no stall for any MEM_LAT.
//   6 Wrap and conflict (ADDR_W=5): store 8'h11 at ans_ex=8'h21, then load 8'h01
//     -> 8'h11. Then mem_rd=mem_wr=1 -> a store occurs and wb_data=ans_ex.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage of the 8-bit MIPS pipeline. It sits between the EX/MEM and MEM/WB
// registers, owns the byte-wide data memory, and stretches loads and stores by
// MEM_LAT wait cycles while holding the upstream pipeline with `stall`.
module mem_stage #(
  parameter int ADDR_W  = 5,
  parameter int MEM_LAT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ans_ex,
  input  logic [7:0] DM_data,
  input  logic       mem_rd,
  input  logic       mem_wr,
  input  logic       wb_en_in,
  input  logic [2:0] rd_in,
  output logic       stall,
  output logic [7:0] wb_data,
  output logic [2:0] wb_rd,
  output logic       wb_en
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit HAS_LAT = (MEM_LAT != 0);
  // Counter preload; a zero-latency build never enters WAIT, so the value is unused there.
  localparam logic [3:0] LAT_LOAD = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t            state, state_next;
  logic [3:0]        cnt, cnt_next;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] addr;
  logic              mem_op;
  logic              is_load;
  logic              commit;
  logic [7:0]        rd_data;

  assign addr    = ans_ex[ADDR_W-1:0];
  assign mem_op  = mem_rd | mem_wr;
  // A simultaneous read and write request behaves as a plain store.
  assign is_load = mem_rd & ~mem_wr;
  // Asynchronous read returns the contents before any store committing at this edge.
  assign rd_data = mem[addr];

  // State register: FSM state and remaining wait count.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: enter WAIT for memory ops when latency is configured, count down, then return.
  always_comb begin
    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (mem_op && HAS_LAT) begin
          state_next = WAIT;
          cnt_next   = LAT_LOAD;
        end
      end
      WAIT: begin
        if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Output logic: stall while the access is still pending; commit on every non-stalled edge.
  always_comb begin
    stall  = 1'b0;
    commit = 1'b0;
    unique case (state)
      IDLE:    stall = mem_op && HAS_LAT;
      WAIT:    stall = (cnt != 4'd0);
      default: stall = 1'b0;
    endcase
    commit = ~stall;
  end

  // Data memory write port; a store lands only when its op commits.
  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset; gating on reset keeps an aborted store from landing.
    if (reset && commit && mem_wr) begin
      mem[addr] <= DM_data;
    end
  end

  // MEM/WB register: load the committed result, or insert a bubble while stalled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_data <= 8'h00;
      wb_rd   <= 3'd0;
      wb_en   <= 1'b0;
    end else if (stall) begin
      wb_en <= 1'b0;
    end else begin
      wb_data <= is_load ? rd_data : ans_ex;
      wb_rd   <= rd_in;
      wb_en   <= wb_en_in;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: three instances at MEM_LAT = 0, 2 and 3 share the
// clock and reset. Inputs change 1 ns after the rising edge; outputs are sampled
// on the falling edge.
module tb_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  typedef struct packed {
    logic [7:0] ans;
    logic [7:0] dm;
    logic       rd;
    logic       wr;
    logic       wen;
    logic [2:0] rdi;
  } op_t;

  localparam op_t NOP = '0;

  op_t in0, in2, in3;

  logic       st0, st2, st3;
  logic [7:0] wd0, wd2, wd3;
  logic [2:0] wr0, wr2, wr3;
  logic       we0, we2, we3;

  mem_stage #(.ADDR_W(5), .MEM_LAT(0)) u_lat0 (
    .clk(clk), .reset(reset), .ans_ex(in0.ans), .DM_data(in0.dm),
    .mem_rd(in0.rd), .mem_wr(in0.wr), .wb_en_in(in0.wen), .rd_in(in0.rdi),
    .stall(st0), .wb_data(wd0), .wb_rd(wr0), .wb_en(we0)
  );

  mem_stage #(.ADDR_W(5), .MEM_LAT(2)) u_lat2 (
    .clk(clk), .reset(reset), .ans_ex(in2.ans), .DM_data(in2.dm),
    .mem_rd(in2.rd), .mem_wr(in2.wr), .wb_en_in(in2.wen), .rd_in(in2.rdi),
    .stall(st2), .wb_data(wd2), .wb_rd(wr2), .wb_en(we2)
  );

  mem_stage #(.ADDR_W(5), .MEM_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .ans_ex(in3.ans), .DM_data(in3.dm),
    .mem_rd(in3.rd), .mem_wr(in3.wr), .wb_en_in(in3.wen), .rd_in(in3.rdi),
    .stall(st3), .wb_data(wd3), .wb_rd(wr3), .wb_en(we3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic op_t mk(input logic [7:0] ans, input logic [7:0] dm, input logic rd,
                             input logic wr, input logic wen, input logic [2:0] rdi);
    op_t o;
    o.ans = ans;
    o.dm  = dm;
    o.rd  = rd;
    o.wr  = wr;
    o.wen = wen;
    o.rdi = rdi;
    return o;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a load pending on the zero-latency instance.
    reset = 1'b0;
    in0 = mk(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0);
    in2 = NOP;
    in3 = NOP;
    tick;
    tick;
    @(negedge clk);
    check("rst_stall0", st0, 1'b0);
    check("rst_wb_en0", we0, 1'b0);
    check("rst_wb_data0", wd0, 8'h00);
    check("rst_wb_rd0", wr0, 3'd0);
    check("rst_wb_en2", we2, 1'b0);
    check("rst_wb_data2", wd2, 8'h00);
    check("rst_wb_en3", we3, 1'b0);
    check("rst_wb_rd3", wr3, 3'd0);

    // Zero latency: store A5 to 0x03, then load it back.
    tick;
    reset = 1'b1;
    in0 = mk(8'h03, 8'hA5, 1'b0, 1'b1, 1'b0, 3'd0);
    @(negedge clk);
    check("l0_store_stall", st0, 1'b0);
    tick;
    in0 = mk(8'h03, 8'h00, 1'b1, 1'b0, 1'b1, 3'd2);
    @(negedge clk);
    check("l0_load_stall", st0, 1'b0);
    check("l0_store_wb_en", we0, 1'b0);
    tick;
    in0 = NOP;
    @(negedge clk);
    check("l0_load_data", wd0, 8'hA5);
    check("l0_load_rd", wr0, 3'd2);
    check("l0_load_en", we0, 1'b1);

    // Address wrap (0x21 aliases 0x01) and simultaneous read+write.
    tick;
    in0 = mk(8'h21, 8'h11, 1'b0, 1'b1, 1'b0, 3'd0);
    @(negedge clk);
    check("wrap_store_stall", st0, 1'b0);
    tick;
    in0 = mk(8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 3'd4);
    tick;
    in0 = mk(8'h09, 8'h66, 1'b1, 1'b1, 1'b1, 3'd3);
    @(negedge clk);
    check("wrap_load_data", wd0, 8'h11);
    check("wrap_load_rd", wr0, 3'd4);
    tick;
    in0 = mk(8'h09, 8'h00, 1'b1, 1'b0, 1'b1, 3'd1);
    @(negedge clk);
    check("rdwr_wb_data", wd0, 8'h09);
    check("rdwr_wb_rd", wr0, 3'd3);
    check("rdwr_wb_en", we0, 1'b1);
    tick;
    in0 = NOP;
    @(negedge clk);
    check("rdwr_stored", wd0, 8'h66);

    // MEM_LAT=2: store 77 to 0x04, then time a load.
    tick;
    in2 = mk(8'h04, 8'h77, 1'b0, 1'b1, 1'b0, 3'd6);
    @(negedge clk);
    check("l2_store_stall_t", st2, 1'b1);
    tick;
    @(negedge clk);
    check("l2_store_stall_t1", st2, 1'b1);
    tick;
    @(negedge clk);
    check("l2_store_stall_t2", st2, 1'b0);
    tick;
    in2 = mk(8'h04, 8'h00, 1'b1, 1'b0, 1'b1, 3'd1);
    @(negedge clk);
    check("l2_load_stall_t", st2, 1'b1);
    check("l2_store_wb_rd", wr2, 3'd6);
    tick;
    @(negedge clk);
    check("l2_load_stall_t1", st2, 1'b1);
    check("l2_load_en_t1", we2, 1'b0);
    check("l2_hold_rd_t1", wr2, 3'd6);
    check("l2_hold_data_t1", wd2, 8'h04);
    tick;
    @(negedge clk);
    check("l2_load_stall_t2", st2, 1'b0);
    check("l2_load_en_t2", we2, 1'b0);
    tick;
    in2 = NOP;
    @(negedge clk);
    check("l2_load_en_t3", we2, 1'b1);
    check("l2_load_data_t3", wd2, 8'h77);
    check("l2_load_rd_t3", wr2, 3'd1);

    // MEM_LAT=3: seed 22 at 0x07, abort a store of 5A by reset, load the old value.
    tick;
    in3 = mk(8'h07, 8'h22, 1'b0, 1'b1, 1'b0, 3'd0);
    @(negedge clk);
    check("l3_seed_stall", st3, 1'b1);
    tick;
    tick;
    tick;
    @(negedge clk);
    check("l3_seed_commit_cycle", st3, 1'b0);
    tick;
    in3 = mk(8'h07, 8'h5A, 1'b0, 1'b1, 1'b0, 3'd0);
    @(negedge clk);
    check("l3_abort_stall_t", st3, 1'b1);
    tick;
    reset = 1'b0;
    @(negedge clk);
    check("l3_abort_stall_t1", st3, 1'b1);
    tick;
    reset = 1'b1;
    in3 = mk(8'h07, 8'h00, 1'b1, 1'b0, 1'b1, 3'd7);
    @(negedge clk);
    check("l3_after_rst_en", we3, 1'b0);
    check("l3_after_rst_stall", st3, 1'b1);
    repeat (3) tick;
    tick;
    in3 = NOP;
    @(negedge clk);
    check("l3_old_data", wd3, 8'h22);
    check("l3_old_en", we3, 1'b1);
    check("l3_old_rd", wr3, 3'd7);

    // ALU pass-through on every latency setting.
    tick;
    in0 = mk(8'h3C, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5);
    in2 = in0;
    in3 = in0;
    @(negedge clk);
    check("pass_stall0", st0, 1'b0);
    check("pass_stall2", st2, 1'b0);
    check("pass_stall3", st3, 1'b0);
    tick;
    in0 = NOP;
    in2 = NOP;
    in3 = NOP;
    @(negedge clk);
    check("pass_data0", wd0, 8'h3C);
    check("pass_rd0", wr0, 3'd5);
    check("pass_en0", we0, 1'b1);
    check("pass_data2", wd2, 8'h3C);
    check("pass_en2", we2, 1'b1);
    check("pass_data3", wd3, 8'h3C);
    check("pass_rd3", wr3, 3'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
